// File: rtl/hpc3_rnd_feeder.sv
// Randomness gearbox feeding the masked HPC3 AND gadgets: re-slices PRNG words into RND_W-bit chunks.
// Optional RND_STARVE_CNT_EN adds a saturating starvation counter output.
module hpc3_rnd_feeder #(
    parameter  int unsigned d        = 2,
    parameter  int unsigned NGADGETS = 1,
    parameter  int unsigned IN_W     = 32,
    localparam int unsigned RND_W    = NGADGETS * d * (d - 1),
    localparam int unsigned CAP      = RND_W + IN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [RND_W-1:0] out_rnd,
    output logic             out_valid,
`ifdef RND_STARVE_CNT_EN
    output logic [15:0]      starve_cnt,
`endif
    input  logic             out_ready
);

    localparam int unsigned CW = $clog2(CAP + 1);

    logic [CAP-1:0] buf_q, buf_d, buf_shifted, word_ext;
    logic [CW-1:0]  cnt_q, cnt_d, cnt1;
    logic           cons, prod;

    assign out_valid = (cnt_q >= CW'(RND_W));
    assign in_ready  = (cnt_q <= CW'(RND_W));
    assign out_rnd   = buf_q[RND_W-1:0];
    assign cons      = out_valid & out_ready;
    assign prod      = in_valid & in_ready;
    assign word_ext  = {{RND_W{1'b0}}, in_data};

    // Consume first, then append the new word directly above the surviving bits.
    always_comb begin
        buf_shifted = buf_q;
        cnt1        = cnt_q;
        if (cons) begin
            buf_shifted = buf_q >> RND_W;
            cnt1        = cnt_q - CW'(RND_W);
        end
        buf_d = buf_shifted;
        cnt_d = cnt1;
        if (prod) begin
            buf_d = buf_shifted | (word_ext << cnt1);
            cnt_d = cnt1 + CW'(IN_W);
        end
        if (flush) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef RND_STARVE_CNT_EN
    logic [15:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (flush)
            starve_d = '0;
        else if (out_ready && !out_valid && (starve_q != '1))
            starve_d = starve_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

    assign starve_cnt = starve_q;
`endif

    // Fill level stays in range and nothing stale sits above it.
    a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= CW'(CAP));
    a_clean_top: assert property (@(posedge clk) disable iff (rst) (buf_q >> cnt_q) == '0);

endmodule

// File: doc/hpc3_rnd_feeder.md
Name: hpc3_rnd_feeder

Overview:
- Randomness gearbox directly upstream of the masked HPC3 AND gadgets; sole driver of their `rnd` bus.
- Accepts fixed-width random words from the PRNG over a valid/ready handshake.
- Re-slices them into exact `RND_W`-bit chunks for one gadget layer per cycle.
- Guarantees each random bit is delivered at most once and never reused.

Parameters:
- d, 2, number of shares per masked bit; must be >= 2.
- NGADGETS, 1, number of HPC3 AND gadgets fed in parallel.
- RND_W, NGADGETS*d*(d-1), localparam: output bits per consume, i.e. the per-gadget HPC3 randomness times NGADGETS.
- IN_W, 32, PRNG word width; must be >= 1.
- CAP, RND_W+IN_W, localparam: buffer capacity in bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- in_data  in  IN_W  fresh random word from the PRNG.
- in_valid  in  1  in_data valid.
- in_ready  out  1  feeder accepts in_data this cycle.
- flush  in  1  synchronous: discard all buffered bits.
- out_rnd  out  RND_W  randomness to the gadgets' rnd inputs.
- out_valid  out  1  out_rnd holds RND_W unused bits.
- out_ready  in  1  gadgets consume out_rnd this cycle.

Behaviour:
- State: bit buffer `buf[CAP-1:0]`; fill counter `cnt`, range 0..CAP, width clog2(CAP+1).
- Reset (async, rst=1): `buf`=0, `cnt`=0. Hence out_valid=0 and out_rnd=0. in_ready is 1 whenever IN_W <= CAP.
- Combinational outputs, all from registered state only:
  - out_valid = (cnt >= RND_W).
  - in_ready = (cnt <= CAP-IN_W), i.e. cnt <= RND_W. in_ready does not depend on out_ready in the same cycle, so there is no combinational path.
  - out_rnd = buf[RND_W-1:0].
- Events per cycle:
  - cons = out_valid & out_ready.
  - prod = in_valid & in_ready.
- Update order within one cycle:
  1. If cons: buf shifts right by RND_W, zero-fill at the top; cnt1 = cnt-RND_W. Otherwise cnt1 = cnt.
  2. If prod: in_data is written at buf[cnt1 +: IN_W]; cnt_next = cnt1+IN_W. Otherwise cnt_next = cnt1.
- Simultaneous cons and prod are both honoured in the same cycle. The new word lands immediately above the surviving bits.
- Bit ordering: LSB of buffered data is always the oldest; out_rnd takes the oldest RND_W bits.
- Invariant: buf bits at and above cnt are always 0. Consumed randomness never remains in any register. Verification asserts this every cycle.
- flush=1, highest priority:
  - Next state is buf=0, cnt=0, regardless of prod or cons.
  - A handshake occurring in a flush cycle is dropped. The PRNG word is considered taken.
- out_valid=0 with out_ready=1 is starvation: no state change. The gadget controller must stall its datapath.
- cnt never exceeds CAP and never underflows; both are formal assertions.
- No latency beyond one register stage: a word accepted in cycle t is visible on out_rnd in cycle t+1 if it completes RND_W bits.
- Reset mid-transfer drops all buffered bits immediately (async). No partial word survives.

Optional Feature:
- Macro: `RND_STARVE_CNT_EN`.
- When defined:
  - Adds output `starve_cnt [15:0]`.
  - Increments when out_ready=1 and out_valid=0; saturates at 16'hFFFF.
  - Cleared by rst (async) and by flush.
  - Used for PRNG throughput tuning.
- When undefined: the port and the counter do not exist; behaviour is otherwise identical.

Test Plan:
- Config d=2, NGADGETS=1, IN_W=3 (RND_W=2, CAP=5):
  - Reset -> out_valid=0, in_ready=1, out_rnd=2'b00, cnt=0.
  - Push 3'b101 -> next cycle cnt=3, out_valid=1, out_rnd=2'b01, in_ready=0.
  - From cnt=3, pop -> cnt=1, buf=...0001. Push 3'b110 -> cnt=4, out_rnd=2'b01. Pop -> cnt=2, out_rnd=2'b11.
  - At cnt=2 (buf=2'b11), pop and push 3'b010 in the same cycle -> cnt=3, out_rnd=2'b10, buf[4:3]=0.
  - At cnt=4, assert flush together with in_valid=1 and out_ready=1 -> cnt=0, buf=0, out_valid=0.
- With `RND_STARVE_CNT_EN`: hold out_ready=1 for 5 cycles after reset with no input -> starve_cnt=5. Force 70000 starved cycles -> starve_cnt=16'hFFFF. Flush -> 0.
